// File: rtl/sprite_blitter.sv
// Sprite blitter: copies a rectangular sprite from a synchronous ROM into the
// 320x240 12-bit frame memory at a signed position, with colour-key and clipping.
module sprite_blitter #(
  parameter int          FB_WIDTH    = 320,
  parameter int          FB_HEIGHT   = 240,
  parameter int          ROM_AW      = 12,
  parameter logic [11:0] TRANSPARENT = 12'hF0F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [10:0]       x_pos,
  input  logic [10:0]       y_pos,
  input  logic [6:0]        spr_w,
  input  logic [6:0]        spr_h,
  input  logic [ROM_AW-1:0] spr_base,
  output logic              busy,
  output logic              done,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic [16:0]       fb_addr,
  output logic [11:0]       fb_data,
  output logic              fb_we
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [11:0] x_lat, y_lat;
  logic [6:0]  w_lat, h_lat;
  logic [6:0]  sx, sy, sx_nxt, sy_nxt;
  logic        drain_cnt;
  logic        zero_size, row_end, last_pix;

  // Stage 1 is aligned with rom_addr, stage 2 with rom_data.
  logic        p1_valid, p1_hit;
  logic [11:0] p1_x, p1_y;
  logic [16:0] p1_addr;
  logic        p2_valid, p2_hit;
  logic [16:0] p2_addr;

  assign zero_size = (spr_w == 7'd0) || (spr_h == 7'd0);
  assign row_end   = (sx == w_lat - 7'd1);
  assign last_pix  = row_end && (sy == h_lat - 7'd1);
  assign sx_nxt    = row_end ? 7'd0 : sx + 7'd1;
  assign sy_nxt    = row_end ? sy + 7'd1 : sy;

  // Sign bit clear plus unsigned compare gives 0 <= coord < limit.
  assign p1_hit  = !p1_x[11] && !p1_y[11] &&
                   (p1_x < 12'(FB_WIDTH)) && (p1_y < 12'(FB_HEIGHT));
  assign p1_addr = 17'(p1_y) * 17'(FB_WIDTH) + 17'(p1_x);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    // NOTE: assigning a default before the case keeps this block free of latches.
    state_nxt = state;
    case (state)
      IDLE:    if (start && !zero_size) state_nxt = RUN;
      RUN:     if (last_pix)            state_nxt = DRAIN;
      DRAIN:   if (drain_cnt)           state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_lat     <= '0;
      y_lat     <= '0;
      w_lat     <= '0;
      h_lat     <= '0;
      sx        <= '0;
      sy        <= '0;
      drain_cnt <= 1'b0;
      done      <= 1'b0;
      rom_addr  <= '0;
      p1_valid  <= 1'b0;
      p1_x      <= '0;
      p1_y      <= '0;
      p2_valid  <= 1'b0;
      p2_hit    <= 1'b0;
      p2_addr   <= '0;
      fb_we     <= 1'b0;
      fb_addr   <= '0;
      fb_data   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          p1_valid <= 1'b0;
          if (start) begin
            x_lat <= {x_pos[10], x_pos};
            y_lat <= {y_pos[10], y_pos};
            w_lat <= spr_w;
            h_lat <= spr_h;
            if (zero_size) begin
              done <= 1'b1;
            end else begin
              rom_addr <= spr_base;
              sx       <= '0;
              sy       <= '0;
              p1_valid <= 1'b1;
              p1_x     <= {x_pos[10], x_pos};
              p1_y     <= {y_pos[10], y_pos};
            end
          end
        end
        RUN: begin
          drain_cnt <= 1'b0;
          if (last_pix) begin
            p1_valid <= 1'b0;
          end else begin
            // Row-major sprite storage makes the ROM address a plain counter.
            rom_addr <= rom_addr + 1'b1;
            sx       <= sx_nxt;
            sy       <= sy_nxt;
            p1_valid <= 1'b1;
            p1_x     <= x_lat + 12'(sx_nxt);
            p1_y     <= y_lat + 12'(sy_nxt);
          end
        end
        DRAIN: begin
          p1_valid  <= 1'b0;
          drain_cnt <= 1'b1;
          if (drain_cnt) done <= 1'b1;
        end
        default: p1_valid <= 1'b0;
      endcase

      p2_valid <= p1_valid;
      p2_hit   <= p1_hit;
      p2_addr  <= p1_addr;

      fb_we <= p2_valid && p2_hit && (rom_data != TRANSPARENT);
      if (p2_valid && p2_hit && (rom_data != TRANSPARENT)) begin
        fb_addr <= p2_addr;
        fb_data <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: table of blits with hand-computed writes,
// plus restart-while-busy and mid-blit reset sequences.
module tb_sprite_blitter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [10:0] x_pos = '0;
  logic [10:0] y_pos = '0;
  logic [6:0]  spr_w = '0;
  logic [6:0]  spr_h = '0;
  logic [11:0] spr_base = '0;
  logic        busy, done, fb_we;
  logic [11:0] rom_addr, fb_data;
  logic [11:0] rom_data = '0;
  logic [16:0] fb_addr;

  logic [11:0] rom [0:4095];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int x, y, w, h, base, done_cyc, rom_hold, nw;
    int wc[4];
    int wa[4];
    int wd[4];
  } vec_t;

  vec_t vecs[8];

  sprite_blitter dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .x_pos    (x_pos),
    .y_pos    (y_pos),
    .spr_w    (spr_w),
    .spr_h    (spr_h),
    .spr_base (spr_base),
    .busy     (busy),
    .done     (done),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .fb_addr  (fb_addr),
    .fb_data  (fb_data),
    .fb_we    (fb_we)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int x, int y, int w, int h, int base, int dc, int hold);
    vec_t v;
    v.x = x; v.y = y; v.w = w; v.h = h; v.base = base;
    v.done_cyc = dc; v.rom_hold = hold; v.nw = 0;
    for (int i = 0; i < 4; i++) begin
      v.wc[i] = 0; v.wa[i] = 0; v.wd[i] = 0;
    end
    return v;
  endfunction

  task automatic addw(input int i, input int c, input int a, input int d);
    vecs[i].wc[vecs[i].nw] = c;
    vecs[i].wa[vecs[i].nw] = a;
    vecs[i].wd[vecs[i].nw] = d;
    vecs[i].nw++;
  endtask

  // Launch one blit, log every cycle until one cycle past done, then compare.
  task automatic run_vec(input vec_t v, input int restart_at, input string tag);
    int first_done = -1;
    int ndone = 0, nbusy = 0, nw = 0, rom_err = 0;
    int npix;
    logic [31:0] gc[8], ga[8], gd[8];
    npix = v.w * v.h;
    @(negedge clk);
    x_pos = 11'(v.x); y_pos = 11'(v.y);
    spr_w = 7'(v.w);  spr_h = 7'(v.h);
    spr_base = 12'(v.base);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = c;
      end
      if (fb_we) begin
        if (nw < 8) begin
          gc[nw] = c; ga[nw] = 32'(fb_addr); gd[nw] = 32'(fb_data);
        end
        nw++;
      end
      if (npix == 0) begin
        if (rom_addr !== 12'(v.rom_hold)) rom_err++;
      end else if (c <= npix && rom_addr !== 12'(v.base + c - 1)) begin
        rom_err++;
      end
      if (c == restart_at) begin
        start = 1'b1; x_pos = 11'd100; y_pos = 11'd100; spr_w = 7'd5;
      end else if (c == restart_at + 1) begin
        start = 1'b0;
      end
      if (first_done >= 0 && c >= first_done + 1) break;
      @(posedge clk); #1;
    end
    check({tag, " done_cycle"}, first_done, v.done_cyc);
    check({tag, " done_count"}, ndone, 1);
    check({tag, " busy_cycles"}, nbusy, v.done_cyc - 1);
    check({tag, " write_count"}, nw, v.nw);
    check({tag, " rom_addr_seq_errors"}, rom_err, 0);
    for (int k = 0; k < v.nw; k++) begin
      check($sformatf("%s w%0d cycle", tag, k), (k < nw) ? gc[k] : 32'hFFFF_FFFF, v.wc[k]);
      check($sformatf("%s w%0d addr", tag, k),  (k < nw) ? ga[k] : 32'hFFFF_FFFF, v.wa[k]);
      check($sformatf("%s w%0d data", tag, k),  (k < nw) ? gd[k] : 32'hFFFF_FFFF, v.wd[k]);
    end
  endtask

  initial begin
    int activity;
    for (int a = 0; a < 4096; a++) rom[a] = 12'(a + 256);
    rom[101] = 12'hF0F;

    // ROM word at address a is (a + 0x100) mod 4096, except 101 which is the key.
    vecs[0] = mk(10, 5, 2, 2, 0, 7, 0);
    addw(0, 3, 1610, 'h100); addw(0, 4, 1611, 'h101);
    addw(0, 5, 1930, 'h102); addw(0, 6, 1931, 'h103);
    vecs[1] = mk(10, 5, 2, 2, 100, 7, 0);
    addw(1, 3, 1610, 'h164); addw(1, 5, 1930, 'h166); addw(1, 6, 1931, 'h167);
    vecs[2] = mk(-1, -1, 3, 2, 0, 9, 0);
    addw(2, 7, 0, 'h104); addw(2, 8, 1, 'h105);
    vecs[3] = mk(318, 239, 4, 2, 0, 11, 0);
    addw(3, 3, 76798, 'h100); addw(3, 4, 76799, 'h101);
    vecs[4] = mk(0, 0, 2, 2, 4095, 7, 0);
    addw(4, 3, 0, 'h0FF); addw(4, 4, 1, 'h100);
    addw(4, 5, 320, 'h101); addw(4, 6, 321, 'h102);
    vecs[5] = mk(0, 0, 0, 5, 50, 1, 2);
    vecs[6] = mk(0, 0, 3, 0, 60, 1, 2);
    vecs[7] = mk(7, 0, 1, 1, 9, 4, 0);
    addw(7, 3, 7, 'h109);

    #12;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset fb_we", fb_we, 0);
    check("reset rom_addr", rom_addr, 0);
    check("reset fb_addr", fb_addr, 0);
    check("reset fb_data", fb_data, 0);
    @(negedge clk) rst = 1'b1;

    run_vec(vecs[0], -1, "basic");
    run_vec(vecs[1], -1, "transparent");
    run_vec(vecs[2], -1, "clip_top_left");
    run_vec(vecs[3], -1, "clip_bottom_right");
    run_vec(vecs[4], -1, "rom_wrap");
    run_vec(vecs[5], -1, "zero_width");
    run_vec(vecs[6], -1, "zero_height");
    run_vec(vecs[0], 2, "restart_ignored");

    // Mid-blit asynchronous reset during cycle 3 of a 4x4 blit.
    @(negedge clk);
    x_pos = '0; y_pos = '0; spr_w = 7'd4; spr_h = 7'd4; spr_base = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b0;
    #1;
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    check("midreset fb_we", fb_we, 0);
    check("midreset rom_addr", rom_addr, 0);
    check("midreset fb_addr", fb_addr, 0);
    check("midreset fb_data", fb_data, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    activity = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (fb_we || busy || done) activity++;
    end
    check("post_reset quiet", activity, 0);
    run_vec(vecs[7], -1, "post_reset_1x1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
